stream_fifo: RTL
================

Name: stream_fifo

Overview:
- Parametrised successor to the single-purpose valid/ready FIFO.
- Generalised in data width and power-of-two depth.
- Adds an optional zero-latency bypass, an occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Sits between pipeline stages as the standard elastic buffer; also replaces the fixed 19-bit instance used at top level.

Parameters:
- WIDTH, 19, payload width in bits (>=1).
- DEPTH_LOG2, 2, log2 of entry count; DEPTH = 2**DEPTH_LOG2; 0 means 1 entry.
- BYPASS, 0, 1 means empty-FIFO push is visible on pop_* in the same cycle.
- AF_THRESH, DEPTH-1, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- flush  in  1  synchronous discard of all contents
- push_valid  in  1  producer has data
- push_data  in  WIDTH  producer payload
- push_ready  out  1  FIFO accepts push this cycle
- pop_valid  out  1  head entry (or bypass data) valid
- pop_data  out  WIDTH  head payload
- pop_ready  in  1  consumer accepts
- count  out  DEPTH_LOG2+1  stored entries, 0..DEPTH
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH

Behaviour:
- Fire rule: push fires = push_valid & push_ready; pop fires = pop_valid & pop_ready. Neither side may combinationally depend on its own ready/valid; producer must hold push_data stable while push_valid is high and push_ready is low.
- Storage is a ring buffer.
  - wr_ptr/rd_ptr are DEPTH_LOG2+1 bits; MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr); full = index bits equal and wrap bits differ.
  - Pointers increment mod 2**(DEPTH_LOG2+1).
  - count = wr_ptr - rd_ptr, unsigned, same width.
- push_ready = !full & !flush & !rst. No push-through-when-full: a simultaneous pop on a full FIFO does not raise push_ready that cycle.
- pop_valid = !empty & !flush (BYPASS=0).
- pop_data = mem[rd_ptr index], read asynchronously.
- Latency, BYPASS=0: pushed word is visible on pop_valid the cycle after the push fires.
- BYPASS=1, empty, push_valid high:
  - pop_valid = 1 and pop_data = push_data combinationally.
  - If pop_ready is also high, the word passes through and is not written; pointers and count do not change.
  - If pop_ready is low, the word is written normally.
- Simultaneous push and pop (not full, not bypassed): both pointers advance and count is unchanged.
- Flush: for one cycle push_ready = 0 and pop_valid = 0, and no fires occur. Next cycle rd_ptr := wr_ptr, giving count = 0. Memory contents are not cleared.
- Reset (rst high at a clock edge): wr_ptr = rd_ptr = 0.
  - While rst is high: push_ready = 0, pop_valid = 0, count = 0, almost_full = 0.
  - almost_empty = 1 during and after reset.
  - The first cycle after rst deasserts: push_ready = 1.
  - Reset mid-transfer drops all contents; any pending push that cycle is ignored.
  - Priority: rst > flush > push/pop.
- DEPTH_LOG2 = 0: single-entry register. full = (count == 1); push_ready is low whenever the entry is held.
- Flags are combinational from count. AF_THRESH/AE_THRESH outside 0..DEPTH are illegal and must be caught by an elaboration-time assertion.
- pop_data when pop_valid = 0 is don't-care. The bench must not check it.

Decomposition:
- fifo_pkg: ptr_t width helper function (DEPTH_LOG2+1) and a default-threshold constant. No structs; the payload stays a flat WIDTH vector.
- Sub-module fifo_mem: DEPTH x WIDTH array with one synchronous write port and one asynchronous read port, no reset on the array. stream_fifo holds pointers, handshake, bypass and flags.

Test Plan:
- Fill/drain (WIDTH=19, DEPTH_LOG2=2, BYPASS=0): push 0x00001..0x00004 with pop_ready=0.
  - Required: push_ready low after the 4th push, count = 4, almost_full = 1.
  - Then pop_ready=1: values pop in order 1,2,3,4; count returns to 0; almost_empty = 1.
- Wrap-around: 10 cycles of continuous push+pop with a 2-entry backlog, data 0x10..0x19.
  - Required: output order preserved across pointer wrap; count stays 2.
- Full with simultaneous pop: FIFO full, push_valid=1, pop_ready=1.
  - Required: one pop fires; push is not accepted that cycle; push accepted next cycle; count goes 4 → 3 → 4.
- Bypass (BYPASS=1): FIFO empty, push 0x7ABCD with pop_ready=1.
  - Required: pop_valid=1 and pop_data=0x7ABCD in the same cycle; count stays 0.
  - Repeat with pop_ready=0: count = 1 next cycle.
- Flush and reset: load 3 entries, assert flush 1 cycle → count=0 and pop_valid=0 next cycle.
  - Reload 2 entries, assert rst 2 cycles → count=0, push_ready=0 during rst, push_ready=1 the first cycle after.
- Depth-1 (DEPTH_LOG2=0): alternate push/pop of 0x00055/0x000AA.
  - Required: push_ready toggles with occupancy; no data loss or duplication.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the stream FIFO family: pointer width and default flag threshold.
package fifo_pkg;

  // Almost-empty fires at or below one stored entry unless overridden.
  localparam int DEFAULT_AE_THRESH = 1;

  // Pointers carry one extra wrap bit above the index so full and empty differ.
  function automatic int ptr_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for stream_fifo: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 19,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam int ENTRIES = 1 << ADDR_W;

  // The array has no reset: contents are only meaningful behind valid pointers.
  logic [WIDTH-1:0] mem_reg [ENTRIES];

  // Write the addressed entry when the FIFO accepts a stored word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Head entry is presented combinationally so it is visible the cycle after a write.
  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/stream_fifo.sv
// Parametrised valid/ready elastic buffer with optional bypass, occupancy count,
// almost-full/almost-empty flags and synchronous flush.
module stream_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH      = 19,
  parameter int DEPTH_LOG2 = 2,
  parameter int BYPASS     = 0,
  parameter int AF_THRESH  = (1 << DEPTH_LOG2) - 1,
  parameter int AE_THRESH  = DEFAULT_AE_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push_valid,
  input  logic [WIDTH-1:0]      push_data,
  output logic                  push_ready,
  output logic                  pop_valid,
  output logic [WIDTH-1:0]      pop_data,
  input  logic                  pop_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = ptr_width(DEPTH_LOG2);
  // A single-entry FIFO still needs a one-bit address into the array.
  localparam int AW    = (DEPTH_LOG2 == 0) ? 1 : DEPTH_LOG2;

  typedef logic [PW-1:0] ptr_t;

  localparam ptr_t FULL_OCC = ptr_t'(DEPTH);

  // Threshold sanity is enforced when the block is elaborated.
  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("stream_fifo: AF_THRESH out of range 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH) begin : g_bad_ae
    $error("stream_fifo: AE_THRESH out of range 0..DEPTH");
  end

  ptr_t wr_ptr_reg, wr_ptr_next;
  ptr_t rd_ptr_reg, rd_ptr_next;
  ptr_t occ;

  logic empty, full;
  logic bypass_active, bypass_through;
  logic push_fire, pop_fire;
  logic wr_en, rd_adv;

  logic [AW-1:0]    wr_addr, rd_addr;
  logic [WIDTH-1:0] mem_rd_data;

  // Occupancy is the modular pointer difference; the wrap bit separates full from empty.
  assign occ   = wr_ptr_reg - rd_ptr_reg;
  assign empty = (occ == '0);
  assign full  = (occ == FULL_OCC);

  if (DEPTH_LOG2 == 0) begin : g_single
    assign wr_addr = '0;
    assign rd_addr = '0;
  end else begin : g_ring
    assign wr_addr = wr_ptr_reg[AW-1:0];
    assign rd_addr = rd_ptr_reg[AW-1:0];
  end

  // Handshake: reset and flush block both sides; bypass forwards a push into an empty FIFO.
  always_comb begin
    bypass_active  = 1'b0;
    bypass_through = 1'b0;
    push_ready     = 1'b0;
    pop_valid      = 1'b0;
    pop_data       = mem_rd_data;
    push_fire      = 1'b0;
    pop_fire       = 1'b0;
    wr_en          = 1'b0;
    rd_adv         = 1'b0;
    if (!rst && !flush) begin
      bypass_active  = (BYPASS != 0) && empty && push_valid;
      push_ready     = !full;
      pop_valid      = !empty || bypass_active;
      if (bypass_active) begin
        pop_data = push_data;
      end
      push_fire      = push_valid && push_ready;
      pop_fire       = pop_valid && pop_ready;
      // A word consumed straight through the bypass never touches storage.
      bypass_through = bypass_active && pop_ready;
      wr_en          = push_fire && !bypass_through;
      rd_adv         = pop_fire && !bypass_through;
    end
  end

  // Next-pointer selection: reset clears both, flush drops contents by catching rd up to wr.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (rst) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else if (flush) begin
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (wr_en) begin
        wr_ptr_next = wr_ptr_reg + ptr_t'(1);
      end
      if (rd_adv) begin
        rd_ptr_next = rd_ptr_reg + ptr_t'(1);
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    wr_ptr_reg <= wr_ptr_next;
    rd_ptr_reg <= rd_ptr_next;
  end

  fifo_mem #(
    .WIDTH  (WIDTH),
    .ADDR_W (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (push_data),
    .rd_addr (rd_addr),
    .rd_data (mem_rd_data)
  );

  // Count and flags read as an empty FIFO while reset is held, even before the first edge.
  always_comb begin
    count        = rst ? '0 : occ;
    almost_full  = !rst && (int'(count) >= AF_THRESH);
    almost_empty = (int'(count) <= AE_THRESH);
  end

endmodule
